// File: rtl/angle_sampler_pkg.sv
// rtl/angle_sampler_pkg.sv - shared types and helpers for the angle sensor sampler
package angle_sampler_pkg;

    localparam int ANGLE_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DONE,
        CALC1,
        CALC2
    } state_t;

    // Difference of two angles on the 4096-count circle, folded to -2048..2047.
    function automatic logic signed [15:0] wrap_delta(input logic [ANGLE_W-1:0] cur,
                                                      input logic [ANGLE_W-1:0] prev);
        logic [ANGLE_W-1:0] d;
        d = cur - prev;
        return $signed({{(16-ANGLE_W){d[ANGLE_W-1]}}, d});
    endfunction

endpackage

// File: rtl/angle_sample_calc.sv
// rtl/angle_sample_calc.sv - offset, pole-pair and delta datapath for one angle sample
module angle_sample_calc
    import angle_sampler_pkg::*;
#(
    parameter logic [7:0] POLE_PAIR = 8'd7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_raw,
    input  logic [15:0]        raw_in,
    input  logic [ANGLE_W-1:0] angle_offset,
    input  logic               calc1,
    input  logic               calc2,
    input  logic               first,
    output logic               raw_bad,
    output logic [ANGLE_W-1:0] mech_angle,
    output logic [ANGLE_W-1:0] phi,
    output logic [15:0]        speed,
    output logic               valid
);

    logic [15:0]        raw_q;
    logic [ANGLE_W-1:0] m_q;
    logic [ANGLE_W-1:0] prev_q;
    logic [ANGLE_W-1:0] phi_next;

    assign raw_bad  = (raw_q[15:12] != 4'd0);
    // Truncating multiply gives the mod-4096 electrical angle directly.
    assign phi_next = m_q * {4'd0, POLE_PAIR};

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q      <= '0;
            m_q        <= '0;
            prev_q     <= '0;
            mech_angle <= '0;
            phi        <= '0;
            speed      <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load_raw) begin
                raw_q <= raw_in;
            end
            if (calc1) begin
                m_q <= raw_q[ANGLE_W-1:0] - angle_offset;
            end
            if (calc2) begin
                mech_angle <= m_q;
                phi        <= phi_next;
                speed      <= first ? 16'd0 : wrap_delta(m_q, prev_q);
                prev_q     <= m_q;
                valid      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/angle_sensor_sampler.sv
// rtl/angle_sensor_sampler.sv - periodic I2C angle read, validation and phi/speed publish
module angle_sensor_sampler
    import angle_sampler_pkg::*;
#(
    parameter logic [23:0] SAMPLE_DIV = 24'd50000,
    parameter logic [23:0] TIMEOUT    = 24'd200000,
    parameter logic [7:0]  POLE_PAIR  = 8'd7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ANGLE_W-1:0] angle_offset,
    input  logic               i2c_ready,
    input  logic               i2c_done,
    input  logic [15:0]        i2c_regout,
    output logic               i2c_start,
    output logic [ANGLE_W-1:0] mech_angle,
    output logic [ANGLE_W-1:0] phi,
    output logic [15:0]        speed,
    output logic               valid,
    output logic               busy,
    output logic               timeout_err,
    output logic               data_err,
    output logic               overrun_err,
    input  logic               err_clr
);

    localparam logic [23:0] DIV_LAST = (SAMPLE_DIV == 24'd0) ? 24'd0 : SAMPLE_DIV - 24'd1;
    localparam logic [23:0] TO_LAST  = (TIMEOUT == 24'd0) ? 24'd0 : TIMEOUT - 24'd1;

    state_t      state, state_d;
    logic [23:0] tick_cnt;
    logic [23:0] to_cnt;
    logic        tick;
    logic        en_d;
    logic        first_q;
    logic        load_raw;
    logic        raw_bad;
    logic        timeout_ev;
    logic        data_ev;
    logic        overrun_ev;

    assign tick = en && (tick_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            to_cnt      <= '0;
            en_d        <= 1'b0;
            first_q     <= 1'b1;
            timeout_err <= 1'b0;
            data_err    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state <= state_d;
            en_d  <= en;
            if (!en || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 24'd1;
            end
            if (state == REQ) begin
                to_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                to_cnt <= to_cnt + 24'd1;
            end
            // A restart condition outranks the clear from a sample publishing this cycle.
            if ((en && !en_d) || timeout_ev) begin
                first_q <= 1'b1;
            end else if (state == CALC2) begin
                first_q <= 1'b0;
            end
            timeout_err <= timeout_ev || (timeout_err && !err_clr);
            data_err    <= data_ev    || (data_err    && !err_clr);
            overrun_err <= overrun_ev || (overrun_err && !err_clr);
        end
    end

    always_comb begin
        state_d    = state;
        i2c_start  = 1'b0;
        busy       = 1'b0;
        load_raw   = 1'b0;
        timeout_ev = 1'b0;
        data_ev    = 1'b0;
        overrun_ev = tick && ((state != IDLE) || !i2c_ready);
        case (state)
            IDLE: begin
                if (tick && i2c_ready) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                i2c_start = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (i2c_done) begin
                    load_raw = 1'b1;
                    state_d  = CALC1;
                end else if (to_cnt == TO_LAST) begin
                    timeout_ev = 1'b1;
                    state_d    = IDLE;
                end
            end
            CALC1: begin
                busy = 1'b1;
                if (raw_bad) begin
                    data_ev = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CALC2;
                end
            end
            CALC2: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    angle_sample_calc #(
        .POLE_PAIR(POLE_PAIR)
    ) u_calc (
        .clk         (clk),
        .rst         (rst),
        .load_raw    (load_raw),
        .raw_in      (i2c_regout),
        .angle_offset(angle_offset),
        .calc1       ((state == CALC1) && !raw_bad),
        .calc2       (state == CALC2),
        .first       (first_q),
        .raw_bad     (raw_bad),
        .mech_angle  (mech_angle),
        .phi         (phi),
        .speed       (speed),
        .valid       (valid)
    );

endmodule

// File: tb/tb_angle_sensor_sampler.sv
// tb/tb_angle_sensor_sampler.sv - self-checking bench for angle_sensor_sampler
module tb_angle_sensor_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [11:0] angle_offset = '0;
    logic        i2c_ready = 1'b1;
    logic        i2c_done = 1'b0;
    logic [15:0] i2c_regout = '0;
    logic        i2c_start;
    logic [11:0] mech_angle;
    logic [11:0] phi;
    logic [15:0] speed;
    logic        valid;
    logic        busy;
    logic        timeout_err;
    logic        data_err;
    logic        overrun_err;
    logic        err_clr = 1'b0;

    angle_sensor_sampler #(
        .SAMPLE_DIV(24'd100),
        .TIMEOUT   (24'd500),
        .POLE_PAIR (8'd7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .angle_offset(angle_offset),
        .i2c_ready   (i2c_ready),
        .i2c_done    (i2c_done),
        .i2c_regout  (i2c_regout),
        .i2c_start   (i2c_start),
        .mech_angle  (mech_angle),
        .phi         (phi),
        .speed       (speed),
        .valid       (valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .data_err    (data_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] mech;
        logic [11:0] phi;
        logic [15:0] speed;
    } exp_t;

    typedef struct {
        logic [15:0] raw;
        logic [11:0] off;
        logic        exp_valid;
        logic [11:0] mech;
        logic [11:0] phi;
        logic [15:0] speed;
        logic        derr;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;
    int   prev_start = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mech_angle", {20'd0, mech_angle}, {20'd0, e.mech});
                chk("phi", {20'd0, phi}, {20'd0, e.phi});
                chk("speed", {16'd0, speed}, {16'd0, e.speed});
                chk("valid_latency", cyc - done_cyc, 32'd3);
            end
        end
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (i2c_start) begin
                ok = 1'b1;
                start_cyc = cyc;
            end
        end
        if (!ok) chk("start_seen", 32'd0, 32'd1);
    endtask

    task automatic pulse_done(input logic [15:0] raw);
        i2c_regout = raw;
        i2c_done   = 1'b1;
        done_cyc   = cyc;
        @(negedge clk);
        i2c_done = 1'b0;
    endtask

    task automatic serve(input logic [15:0] raw, input logic exp_valid, input logic [11:0] m,
                         input logic [11:0] p, input logic [15:0] s);
        exp_t e;
        repeat (39) @(negedge clk);
        if (exp_valid) begin
            e.mech = m; e.phi = p; e.speed = s;
            sb.push_back(e);
        end
        pulse_done(raw);
        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out"}, {mech_angle, phi, speed}, 32'd0);
        chk({tag, "_flags"}, {27'd0, valid, busy, timeout_err, data_err, overrun_err}, 32'd0);
        chk({tag, "_start"}, {31'd0, i2c_start}, 32'd0);
    endtask

    initial begin
        bit ok;
        int n;
        bit saw;
        vt[0] = '{16'h0123, 12'd0,  1'b1, 12'h123, 12'h7F5, 16'h0000, 1'b0};
        vt[1] = '{16'h0FFA, 12'd0,  1'b1, 12'd4090, 12'd4054, 16'hFED7, 1'b0};
        vt[2] = '{16'h0006, 12'd0,  1'b1, 12'd6,    12'd42,   16'h000C, 1'b0};
        vt[3] = '{16'h0FFA, 12'd0,  1'b1, 12'd4090, 12'd4054, 16'hFFF4, 1'b0};
        vt[4] = '{16'h0005, 12'd10, 1'b1, 12'd4091, 12'd4061, 16'h0001, 1'b0};
        vt[5] = '{16'h1123, 12'd0,  1'b0, 12'd0,    12'd0,    16'h0000, 1'b1};
        vt[6] = '{16'h0100, 12'd0,  1'b1, 12'h100,  12'h700,  16'h0105, 1'b0};
        vt[7] = '{16'h0900, 12'd0,  1'b1, 12'h900,  12'hF00,  16'hF800, 1'b0};
        vt[8] = '{16'h0FFF, 12'hFFF, 1'b1, 12'h000, 12'h000,  16'h0700, 1'b0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 9; i++) begin
            angle_offset = vt[i].off;
            wait_start(ok);
            if (ok) begin
                if (prev_start >= 0) chk("start_period", start_cyc - prev_start, 32'd100);
                prev_start = start_cyc;
                serve(vt[i].raw, vt[i].exp_valid, vt[i].mech, vt[i].phi, vt[i].speed);
                chk("data_err", {31'd0, data_err}, {31'd0, vt[i].derr});
                clear_errors();
                chk("data_err_clr", {31'd0, data_err}, 32'd0);
            end
        end

        // Read never completes: abandon after TIMEOUT, ignore a late done, restart speed at 0.
        angle_offset = 12'd0;
        wait_start(ok);
        if (ok) begin
            repeat (450) @(negedge clk);
            chk("timeout_early", {31'd0, timeout_err}, 32'd0);
            repeat (60) @(negedge clk);
            chk("timeout_set", {31'd0, timeout_err}, 32'd1);
            repeat (2) @(negedge clk);
            pulse_done(16'h0200);
            repeat (4) @(negedge clk);
            clear_errors();
            chk("timeout_clr", {30'd0, timeout_err, overrun_err}, 32'd0);
        end
        wait_start(ok);
        if (ok) serve(16'h0300, 1'b1, 12'h300, 12'h500, 16'h0000);

        // Upstream not ready at tick.
        i2c_ready = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (i2c_start) saw = 1'b1;
        end
        chk("overrun_no_start", {31'd0, saw}, 32'd0);
        chk("overrun_set", {31'd0, overrun_err}, 32'd1);
        i2c_ready = 1'b1;

        // Reset in the middle of a read.
        wait_start(ok);
        if (ok) begin
            repeat (10) @(negedge clk);
            chk("busy_wait", {31'd0, busy}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero("midrst");
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            pulse_done(16'h0555);
            n = 0;
            saw = 1'b0;
            while (!saw && n < 200) begin
                @(negedge clk);
                n++;
                if (i2c_start) saw = 1'b1;
            end
            chk("restart_delay", {31'd0, (saw && n >= 90 && n <= 105)}, 32'd1);
            if (saw) serve(16'h0123, 1'b1, 12'h123, 12'h7F5, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
